// File: rtl/i2s_tx.sv
// i2s_tx: stereo Philips-I2S transmitter fed by a pair of first-word-fall-through
// FIFOs. One left/right pair is popped per frame, shifted and saturated to
// SAMPLE_WIDTH, then shifted out MSB first. Missing pairs become silent frames.
module i2s_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SHIFT        = 0,
  parameter int BCLK_DIV     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left_dout,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_dout,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int SW     = SAMPLE_WIDTH;
  localparam int FW     = 2 * SAMPLE_WIDTH;
  localparam int SLOT_W = $clog2(FW);
  localparam int DIV_W  = $clog2(BCLK_DIV);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FW - 1);
  localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(SW - 1);
  localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(FW - 2);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);

  // Saturation bounds expressed at the FIFO word width so the compare is signed.
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH - SW + 1){1'b0}}, {(SW - 1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {{(DATA_WIDTH - SW + 1){1'b1}}, {(SW - 1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]     hold_l, hold_r;
  logic              hold_valid;
  logic [FW-1:0]     shifter;
  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot;

  logic              start;       // IDLE -> RUN, first frame load
  logic              div_wrap;    // half-period boundary of bclk
  logic              bclk_fall;   // bclk is about to go 1 -> 0
  logic              frame_load;  // falling edge that enters slot 0
  logic              pop;
  logic [SLOT_W-1:0] slot_next;
  logic              lr_next;

  // Arithmetic shift followed by clamping into the signed SW-bit range.
  function automatic logic [SW-1:0] convert(input logic [DATA_WIDTH-1:0] word);
    logic signed [DATA_WIDTH-1:0] shifted;
    shifted = $signed(word) >>> SHIFT;
    if (shifted > SAT_MAX) begin
      return SAT_MAX[SW-1:0];
    end else if (shifted < SAT_MIN) begin
      return SAT_MIN[SW-1:0];
    end
    return shifted[SW-1:0];
  endfunction

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_d    = state_q;
    start      = 1'b0;
    div_wrap   = 1'b0;
    bclk_fall  = 1'b0;
    frame_load = 1'b0;
    pop        = 1'b0;
    slot_next  = slot + SLOT_W'(1);
    lr_next    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_valid) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        div_wrap   = (div_cnt == DIV_LAST);
        bclk_fall  = div_wrap && i2s_bclk;
        frame_load = bclk_fall && (slot == LAST_SLOT);
      end
      default: state_d = IDLE;
    endcase

    if (slot == LAST_SLOT) begin
      slot_next = '0;
    end
    // lrclk switches one slot ahead of the channel MSB (I2S one-bit delay).
    lr_next = (slot_next >= LR_FIRST) && (slot_next <= LR_LAST);

    // Both FIFOs must have a word; a frame-load cycle never pops, so a pair
    // arriving exactly then is picked up one cycle later.
    pop = !reset && !hold_valid && !left_empty && !right_empty && !frame_load;
  end

  assign left_rd_en  = pop;
  assign right_rd_en = pop;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every always_ff reads the
    // pre-edge value of every other register, independent of block ordering.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register: filled by a pop, emptied by a frame load.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_l     <= '0;
      hold_r     <= '0;
      hold_valid <= 1'b0;
    end else if (pop) begin
      hold_l     <= convert(left_dout);
      hold_r     <= convert(right_dout);
      hold_valid <= 1'b1;
    end else if (start || (frame_load && hold_valid)) begin
      hold_valid <= 1'b0;
    end
  end

  // Bit-clock divider and slot counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      slot     <= '0;
      i2s_bclk <= 1'b0;
    end else if (start) begin
      div_cnt  <= '0;
      slot     <= '0;
      i2s_bclk <= 1'b0;
    end else if (state_q == RUN) begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        i2s_bclk <= ~i2s_bclk;
      end
      if (bclk_fall) begin
        slot <= slot_next;
      end
    end
  end

  // Frame shifter, word select and serial data, all updated on bclk falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      shifter   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (start) begin
      shifter   <= {hold_l, hold_r};
      i2s_lrclk <= 1'b0;
      i2s_sdata <= hold_l[SW-1];
    end else if (bclk_fall) begin
      i2s_lrclk <= lr_next;
      if (frame_load) begin
        if (hold_valid) begin
          shifter   <= {hold_l, hold_r};
          i2s_sdata <= hold_l[SW-1];
        end else begin
          shifter   <= '0;
          i2s_sdata <= 1'b0;
        end
      end else begin
        shifter   <= shifter << 1;
        i2s_sdata <= shifter[FW-2];
      end
    end
  end

  // Underrun pulse and saturating count of silent frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= frame_load && !hold_valid;
      if (frame_load && !hold_valid && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

endmodule
